bp_pht_predictor: RTL
=====================

Name: bp_pht_predictor

Overview:
- Parametrised branch direction predictor: a pattern history table (PHT) of 2^IDX_W saturating counters, each CTR_W bits wide.
- Indexed either by PC bits alone (bimodal) or by PC bits XOR a global history register (gshare).
- Sits beside the IF/ID stage.
  - Lookup is combinational in the fetch cycle.
  - Update arrives later from the EX stage, carrying the index and prediction captured at lookup.
- Also maintains saturating performance counters for resolved branches and mispredicts.

Parameters:
- PC_W, 32, width of the program counter input.
- IDX_W, 6, PHT index width; table holds 2^IDX_W entries; legal range 1..(PC_W-2).
- CTR_W, 2, counter width per entry; legal range 1..4.
- GHR_W, 6, global history length; legal range 1..IDX_W; ignored when MODE=0.
- MODE, 1, 0 = bimodal (index = PC only), 1 = gshare (index = PC XOR history).
- PERF_W, 16, width of the performance counters.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-low reset.
- pc_i  input  PC_W  PC of the instruction being looked up.
- predict_o  output  1  1 = predict taken; combinational from pc_i and current state.
- pred_idx_o  output  IDX_W  PHT index used for this lookup; carried down the pipeline.
- update_i  input  1  1 = a branch resolved this cycle.
- update_idx_i  input  IDX_W  index returned from pred_idx_o of that branch.
- update_pred_i  input  1  prediction originally made for that branch.
- result_i  input  1  actual outcome, 1 = taken.
- ghr_o  output  GHR_W  current global history; LSB = most recent outcome.
- upd_cnt_o  output  PERF_W  number of updates seen, saturating.
- miss_cnt_o  output  PERF_W  number of mispredicts seen, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - Reset is sampled only at a rising clk_i edge with rst_i=0.
- Reset values:
  - Every PHT entry = 2^(CTR_W-1)-1, i.e. weakly not-taken (01 for CTR_W=2).
  - GHR = 0; upd_cnt_o = 0; miss_cnt_o = 0.
  - After reset, predict_o = 0 for every pc_i.
- Reset mid-operation: reset wins over a simultaneous update_i; no entry, GHR or counter changes in that cycle except to the reset values.
- Index formation:
  - pc_idx = pc_i[IDX_W+1:2] (word-aligned).
  - MODE=0: pred_idx_o = pc_idx.
  - MODE=1: pred_idx_o = pc_idx XOR zero-extended GHR (GHR occupies the low GHR_W bits).
- Prediction: predict_o = MSB of PHT[pred_idx_o]. Zero latency; purely combinational from registered state.
- Update (on the clock edge with rst_i=1 and update_i=1):
  - result_i=1: PHT[update_idx_i] increments, saturating at 2^CTR_W-1.
  - result_i=0: PHT[update_idx_i] decrements, saturating at 0.
  - GHR <= {GHR[GHR_W-2:0], result_i}. When GHR_W=1, GHR <= result_i.
  - GHR is updated in both modes; it is only used for indexing when MODE=1.
  - upd_cnt_o increments, saturating at all ones.
  - miss_cnt_o increments, saturating at all ones, iff update_pred_i != result_i.
  - With update_i=0, nothing changes.
- Simultaneous lookup and update in the same cycle:
  - The lookup sees pre-update state, including for the same index and the old GHR.
  - The new value is visible from the next cycle.
- History is non-speculative: it is updated only at resolution, never at lookup.
- update_idx_i is used as given; it is never recomputed from a PC.
- Out-of-range values are impossible by width; all indices are legal.

Test Plan:
- Reset and defaults: MODE=0, CTR_W=2. Drive rst_i=0 for one edge, then sweep pc_i = 0x00..0xFC → predict_o=0, pred_idx_o = pc_i[7:2], ghr_o=0, upd_cnt_o=0, miss_cnt_o=0.
- Saturation up/down: at idx 5, apply 4 taken updates → entry saturates at 3 and predict_o=1 after the first update. Then apply 4 not-taken updates → predict_o=0 after the 2nd, entry saturates at 0. Apply 1 taken → entry 1, predict_o still 0.
- Gshare indexing: MODE=1, GHR_W=6. Apply updates with outcomes 1,0,1,1 → ghr_o=6'b001011. Then pc_i=0x40 (pc_idx=16) → pred_idx_o = 16 XOR 11 = 27.
- Same-cycle read/write: hold pc_i on idx 9 (weakly not-taken), with update_i=1, update_idx_i=9, result_i=1 → predict_o=0 in that cycle and 1 in the next.
- Perf counters: PERF_W=4. Apply 20 updates, alternating update_pred_i against a constant result_i=1 (10 mispredicts) → upd_cnt_o saturates at 15, miss_cnt_o=10.
- Reset during update: rst_i=0 together with update_i=1, result_i=1 on an entry at 1 → after the edge, entry=1, ghr_o=0, upd_cnt_o=0.

Source files
------------

// File: rtl/bp_pht_predictor.sv
// Branch direction predictor: PHT of saturating counters, bimodal or gshare indexed,
// with non-speculative global history and saturating update/mispredict counters.
module bp_pht_predictor #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int GHR_W  = 6,
    parameter int MODE   = 1,
    parameter int PERF_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              predict_o,
    output logic [IDX_W-1:0]  pred_idx_o,
    input  logic              update_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              update_pred_i,
    input  logic              result_i,
    output logic [GHR_W-1:0]  ghr_o,
    output logic [PERF_W-1:0] upd_cnt_o,
    output logic [PERF_W-1:0] miss_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0]  r_pht [ENTRIES];
    logic [GHR_W-1:0]  r_ghr;
    logic [PERF_W-1:0] r_upd_cnt;
    logic [PERF_W-1:0] r_miss_cnt;

    logic [IDX_W-1:0]  w_pc_idx;
    logic [IDX_W-1:0]  w_idx;
    logic [GHR_W-1:0]  w_ghr_nxt;
    logic [CTR_W-1:0]  w_ctr_cur;
    logic [CTR_W-1:0]  w_ctr_nxt;
    logic              w_unused_pc;

    assign w_pc_idx    = pc_i[IDX_W+1:2];
    assign w_unused_pc = ^pc_i;

    generate
        if (MODE == 1) begin : g_gshare
            assign w_idx = w_pc_idx ^ IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_idx = w_pc_idx;
        end

        if (GHR_W == 1) begin : g_ghr1
            assign w_ghr_nxt = result_i;
        end else begin : g_ghrn
            assign w_ghr_nxt = {r_ghr[GHR_W-2:0], result_i};
        end
    endgenerate

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign pred_idx_o = w_idx;
    assign predict_o  = r_pht[w_idx][CTR_W-1];
    assign ghr_o      = r_ghr;
    assign upd_cnt_o  = r_upd_cnt;
    assign miss_cnt_o = r_miss_cnt;

    always_comb begin
        w_ctr_cur = r_pht[update_idx_i];
        w_ctr_nxt = w_ctr_cur;
        if (result_i) begin
            if (w_ctr_cur != '1) w_ctr_nxt = w_ctr_cur + CTR_W'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) r_pht[i] <= CTR_INIT;
            r_ghr      <= '0;
            r_upd_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (update_i) begin
            r_pht[update_idx_i] <= w_ctr_nxt;
            r_ghr               <= w_ghr_nxt;
            if (r_upd_cnt != '1) r_upd_cnt <= r_upd_cnt + PERF_W'(1);
            if ((update_pred_i != result_i) && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + PERF_W'(1);
        end
    end

endmodule
